// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch resolver: funct3 codes,
// FSM states, bimodal counter encodings and the decode/saturation helpers.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_STRONG_NT = 2'b00;
    localparam bht_ctr_t BHT_WEAK_NT   = 2'b01;
    localparam bht_ctr_t BHT_WEAK_T    = 2'b10;
    localparam bht_ctr_t BHT_STRONG_T  = 2'b11;

    // 010 and 011 are the only funct3 codes with no branch meaning.
    function automatic logic f3_legal(input logic [2:0] f3);
        return !(!f3[2] && f3[1]);
    endfunction

    function automatic logic f3_taken(input logic [2:0] f3, input logic lt, input logic eq);
        logic t;
        case (f3)
            F3_BEQ:           t = eq;
            F3_BNE:           t = !eq;
            F3_BLT, F3_BLTU:  t = lt;
            F3_BGE, F3_BGEU:  t = !lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic bht_ctr_t bht_next(input bht_ctr_t c, input logic tk);
        if (tk) begin
            return (c == BHT_STRONG_T) ? c : c + 2'd1;
        end
        return (c == BHT_STRONG_NT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Pipeline-facing bundle of the branch resolver: fetch prediction port,
// execute branch inputs, comparator link and redirect/flush outputs.
interface branch_resolver_if;
    import branch_pkg::*;

    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        BrUn;
    logic        BrLT;
    logic        BrEq;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    state_t      dbg_state;

    // ex_valid has no ready: a branch is consumed in any cycle the resolver is
    // not flushing, and silently dropped while flush is high (those stages are
    // being squashed anyway). redirect_valid is a one-cycle pulse, also unacked.
    modport master (
        output if_pc, ex_valid, ex_funct3, ex_pc, ex_target, ex_pred_taken, BrLT, BrEq,
        input  if_pred_taken, BrUn, redirect_valid, redirect_pc, flush, dbg_state
    );

    modport slave (
        input  if_pc, ex_valid, ex_funct3, ex_pc, ex_target, ex_pred_taken, BrLT, BrEq,
        output if_pred_taken, BrUn, redirect_valid, redirect_pc, flush, dbg_state
    );

endinterface

// File: rtl/branch_history_table.sv
// Bimodal 2-bit counter array: combinational read for fetch, saturating
// update from execute. A same-index read sees the pre-update value.
module branch_history_table
    import branch_pkg::*;
#(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_ctr_t ctr_q [ENTRIES];
    bht_ctr_t ctr_d [ENTRIES];

    assign rd_taken = ctr_q[rd_idx][1];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            ctr_d[upd_idx] = bht_next(ctr_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_WEAK_NT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: taken decode, mispredict redirect/flush FSM
// and BHT ownership. Define BRANCH_STATS_EN to add branch/mispredict counters.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input logic              clk,
    input logic              rst_n,
    branch_resolver_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      branch_count,
    output logic [31:0]      mispredict_count
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               legal, taken, resolve, mispredict;
    logic               unused_pc_bits;

    assign bus.BrUn   = bus.ex_funct3[1];
    assign legal      = f3_legal(bus.ex_funct3);
    assign taken      = f3_taken(bus.ex_funct3, bus.BrLT, bus.BrEq);
    assign resolve    = bus.ex_valid && (state_q == ST_IDLE) && legal;
    assign mispredict = resolve && (taken != bus.ex_pred_taken);

    assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

    branch_history_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (bus.if_pc[IDX_W+1:2]),
        .rd_taken  (bus.if_pred_taken),
        .upd_en    (resolve),
        .upd_idx   (bus.ex_pc[IDX_W+1:2]),
        .upd_taken (taken)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d          = ST_FLUSH;
                    cnt_d            = CNT_W'(FLUSH_CYCLES);
                    redirect_valid_d = 1'b1;
                    // Wraps naturally at 2^32 for a branch at 0xFFFFFFFC.
                    redirect_pc_d    = taken ? bus.ex_target : bus.ex_pc + 32'd4;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = (state_q == ST_FLUSH);
    assign bus.dbg_state      = state_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    always_comb begin
        branch_count_d     = resolve ? branch_count_q + 32'd1 : branch_count_q;
        mispredict_count_d = mispredict ? mispredict_count_q + 32'd1 : mispredict_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: behavioural model of the BHT, redirect
// and flush window, per-cycle comparison plus hand-computed spot checks.
module tb_branch_resolver;
    import branch_pkg::*;

    localparam int ENTRIES = 16;
    localparam int FLUSH   = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    branch_resolver_if bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    branch_resolver #(.BHT_ENTRIES(ENTRIES), .FLUSH_CYCLES(FLUSH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BRANCH_STATS_EN
        ,
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int          m_bht [ENTRIES] = '{default: 1};
    logic        m_rv        = 1'b0;
    logic [31:0] m_rpc       = '0;
    int          m_flush_left = 0;
    logic [31:0] m_bc        = '0;
    logic [31:0] m_mc        = '0;
    logic [31:0] exp_q [$];

    function automatic int model_legal(input logic [2:0] f3);
        return (f3 == 3'd2 || f3 == 3'd3) ? 0 : 1;
    endfunction

    function automatic logic model_taken(input logic [2:0] f3, input logic lt, input logic eq);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic int pc_index(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(ENTRIES));
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            foreach (m_bht[i]) m_bht[i] = 1;
            m_rv = 1'b0; m_rpc = '0; m_flush_left = 0; m_bc = '0; m_mc = '0;
            exp_q.delete();
        end else begin
            m_rv = 1'b0;
            if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (bus.ex_valid && model_legal(bus.ex_funct3) == 1) begin
                logic tk;
                int   idx;
                tk  = model_taken(bus.ex_funct3, bus.BrLT, bus.BrEq);
                idx = pc_index(bus.ex_pc);
                if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
                else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
                m_bc++;
                if (tk != bus.ex_pred_taken) begin
                    m_mc++;
                    m_rv  = 1'b1;
                    m_rpc = tk ? bus.ex_target : bus.ex_pc + 32'd4;
                    exp_q.push_back(m_rpc);
                    m_flush_left = FLUSH;
                end
            end
        end
    end

    // ---------------- per-cycle compare / scoreboard ----------------
    initial forever begin
        @(negedge clk);
        check("pred", 32'(bus.if_pred_taken), 32'(m_bht[pc_index(bus.if_pc)] >= 2));
        check("brun", 32'(bus.BrUn), 32'(bus.ex_funct3 inside {3'd2, 3'd3, 3'd6, 3'd7}));
        check("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
        check("redirect_pc", bus.redirect_pc, m_rpc);
        check("flush", 32'(bus.flush), 32'(m_flush_left > 0));
        check("state", 32'(bus.dbg_state), 32'((m_flush_left > 0) ? ST_FLUSH : ST_IDLE));
`ifdef BRANCH_STATS_EN
        check("branch_count", branch_count, m_bc);
        check("mispredict_count", mispredict_count, m_mc);
`endif
        if (bus.redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL redirect_sb actual=%h expected=none", bus.redirect_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.redirect_pc !== e) begin
                    errors++;
                    $display("FAIL redirect_sb actual=%h expected=%h", bus.redirect_pc, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic pred, input logic lt, input logic eq);
        bus.ex_valid      = 1'b1;
        bus.ex_funct3     = f3;
        bus.ex_pc         = pc;
        bus.ex_target     = tgt;
        bus.ex_pred_taken = pred;
        bus.BrLT          = lt;
        bus.BrEq          = eq;
    endtask

    task automatic idle(input int n);
        bus.ex_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.if_pc = '0; bus.ex_valid = 1'b0; bus.ex_funct3 = '0; bus.ex_pc = '0;
        bus.ex_target = '0; bus.ex_pred_taken = 1'b0; bus.BrLT = 1'b0; bus.BrEq = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        bus.if_pc = 32'h100;
        #1;
        check("reset_pred", 32'(bus.if_pred_taken), 32'd0);
        check("reset_rv", 32'(bus.redirect_valid), 32'd0);
        check("reset_rpc", bus.redirect_pc, 32'h0);
        check("reset_flush", 32'(bus.flush), 32'd0);

        // Illegal funct3 with a "wrong" prediction: nothing happens.
        drive_br(3'b011, 32'h100, 32'h180, 1'b1, 1'b0, 1'b1);
        step();
        check("illegal_rv", 32'(bus.redirect_valid), 32'd0);
        check("illegal_flush", 32'(bus.flush), 32'd0);

        // BEQ taken, predicted not taken.
        drive_br(F3_BEQ, 32'h100, 32'h140, 1'b0, 1'b0, 1'b1);
        step();
        check("beq_rv_n1", 32'(bus.redirect_valid), 32'd1);
        check("beq_rpc_n1", bus.redirect_pc, 32'h140);
        check("beq_flush_n1", 32'(bus.flush), 32'd1);
        idle(1);
        check("beq_rv_n2", 32'(bus.redirect_valid), 32'd0);
        check("beq_flush_n2", 32'(bus.flush), 32'd1);
        check("beq_rpc_hold", bus.redirect_pc, 32'h140);
        idle(1);
        check("beq_flush_n3", 32'(bus.flush), 32'd0);
        check("beq_bht_weak_t", 32'(bus.if_pred_taken), 32'd1);
`ifdef BRANCH_STATS_EN
        check("stats_bc_1", branch_count, 32'd1);
        check("stats_mc_1", mispredict_count, 32'd1);
`endif

        // BLTU: unsigned select, not taken against a taken prediction.
        bus.ex_funct3 = F3_BLTU;
        #1 check("brun_bltu_idle", 32'(bus.BrUn), 32'd1);
        drive_br(F3_BLTU, 32'h200, 32'h280, 1'b1, 1'b0, 1'b0);
        step();
        check("bltu_rpc", bus.redirect_pc, 32'h204);
        idle(2);
        drive_br(F3_BLTU, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b0);
        step();
        check("bltu_wrap_rv", 32'(bus.redirect_valid), 32'd1);
        check("bltu_wrap_rpc", bus.redirect_pc, 32'h0);
        idle(2);

        // Mispredict, then branches in N+1 and N+2 which must be ignored.
        bus.if_pc = 32'h300;
        drive_br(F3_BEQ, 32'h300, 32'h340, 1'b1, 1'b0, 1'b0);
        step();
        check("ign_rpc", bus.redirect_pc, 32'h304);
        drive_br(F3_BNE, 32'h300, 32'h360, 1'b0, 1'b0, 1'b0);
        step();
        check("ign_rv_n2", 32'(bus.redirect_valid), 32'd0);
        step();
        bus.ex_valid = 1'b0;
        #1;
        check("ign_rv_n3", 32'(bus.redirect_valid), 32'd0);
        check("ign_flush_n3", 32'(bus.flush), 32'd0);
        check("ign_rpc_hold", bus.redirect_pc, 32'h304);
        check("ign_pred", 32'(bus.if_pred_taken), 32'd0);

        // Four taken BNE back-to-back at index 0 (counter starts at 00).
        bus.if_pc = 32'h400;
        drive_br(F3_BNE, 32'h400, 32'h480, 1'b1, 1'b0, 1'b0);
        #1 check("sat_pred_00", 32'(bus.if_pred_taken), 32'd0);
        step();
        check("same_cycle_old", 32'(bus.if_pred_taken), 32'd0);
        step();
        check("sat_pred_10", 32'(bus.if_pred_taken), 32'd1);
        step();
        step();
        bus.ex_valid = 1'b0;
        #1;
        check("sat_no_rv", 32'(bus.redirect_valid), 32'd0);
        check("sat_no_flush", 32'(bus.flush), 32'd0);
        drive_br(F3_BNE, 32'h400, 32'h480, 1'b1, 1'b0, 1'b1);
        step();
        check("sat_nt_rpc", bus.redirect_pc, 32'h404);
        check("sat_pred_after_dec", 32'(bus.if_pred_taken), 32'd1);
        idle(2);

        // Reset asserted in N+1 of a flush.
        drive_br(F3_BEQ, 32'h500, 32'h600, 1'b0, 1'b0, 1'b1);
        step();
        check("rst_pre_rv", 32'(bus.redirect_valid), 32'd1);
        check("rst_pre_rpc", bus.redirect_pc, 32'h600);
        bus.ex_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_flush", 32'(bus.flush), 32'd0);
        check("rst_mid_rv", 32'(bus.redirect_valid), 32'd0);
        check("rst_mid_rpc", bus.redirect_pc, 32'h0);
        check("rst_mid_pred", 32'(bus.if_pred_taken), 32'd0);
`ifdef BRANCH_STATS_EN
        check("rst_mid_mc", mispredict_count, 32'd0);
`endif
        step();
        rst_n = 1'b1;

        // Correctly predicted branches resolving every cycle.
        bus.if_pc = 32'h20;
        drive_br(F3_BLT, 32'h20, 32'h80, 1'b1, 1'b1, 1'b0);
        step();
        drive_br(F3_BGEU, 32'h24, 32'h90, 1'b0, 1'b1, 1'b0);
        step();
        drive_br(F3_BGE, 32'h28, 32'hA0, 1'b1, 1'b0, 1'b0);
        step();
        bus.ex_valid = 1'b0;
        #1;
        check("b2b_no_rv", 32'(bus.redirect_valid), 32'd0);
        check("b2b_pred_20", 32'(bus.if_pred_taken), 32'd1);
        idle(3);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
